squeeze_kernel_server: RTL and testbench

Responder side of the squeeze-kernel request/ready handshake used by the squeeze convolution engine. It holds one layer's squeeze kernels, loaded by the host as paired 64-bit words (3x3 and 1x1) in two on-chip RAMs. On each one-cycle `squ_ker_req_i` pulse it returns the next kernel pair with a one-cycle `squ_ker_ready_o` pulse. It sits beside the max-pool/squeeze top and feeds its kernel inputs directly.

---
 rtl/squ_ker_pkg.sv | 34 +++
 rtl/squ_ker_ram.sv | 44 ++++
 rtl/squeeze_kernel_server.sv | 198 +++++++++++++++++++
 tb/tb_squeeze_kernel_server.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/squ_ker_pkg.sv
// -----------------------------------------------------------------------------
// squ_ker_pkg
// Shared constants, FSM state type and read-pointer helper for the
// squeeze-kernel server.
//
// Contents:
//   KER_DEPTH   - words per kernel RAM
//   KER_W       - kernel word width
//   KER_AW      - kernel RAM address width
//   squ_state_e - server FSM states (IDLE, RUN, RD, LAT)
//   next_rd_ptr - advance the read pointer, wrapping after the layer limit
// -----------------------------------------------------------------------------
package squ_ker_pkg;

    localparam int KER_DEPTH = 512;
    localparam int KER_W     = 64;
    localparam int KER_AW    = $clog2(KER_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RD   = 2'd2,
        LAT  = 2'd3
    } squ_state_e;

    // The limit is the last address of the layer, so it is inclusive.
    function automatic logic [KER_AW-1:0] next_rd_ptr(
        input logic [KER_AW-1:0] rd_ptr,
        input logic [KER_AW-1:0] limit
    );
        return (rd_ptr == limit) ? '0 : rd_ptr + 1'b1;
    endfunction

endpackage

// File: rtl/squ_ker_ram.sv
// -----------------------------------------------------------------------------
// squ_ker_ram
// Simple dual-port synchronous RAM: one write port, one read port, one cycle
// of read latency. The read register holds its value while rd_en_i is low,
// so a word fetched once stays on rd_data_o until the next read.
//
// Ports:
//   clk_i      in  1      clock
//   wr_en_i    in  1      write strobe
//   wr_addr_i  in  AW     write address
//   wr_data_i  in  W      write data
//   rd_en_i    in  1      read strobe
//   rd_addr_i  in  AW     read address
//   rd_data_o  out W      read data, valid the cycle after rd_en_i
// -----------------------------------------------------------------------------
module squ_ker_ram
    import squ_ker_pkg::*;
#(
    parameter int DEPTH = KER_DEPTH,
    parameter int W     = KER_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem [DEPTH];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/squeeze_kernel_server.sv
// -----------------------------------------------------------------------------
// squeeze_kernel_server
// Responder side of the squeeze-kernel request/ready handshake. The host loads
// one layer's kernels as paired 3x3 / 1x1 words; each request pulse from the
// convolution engine is answered with the next pair and a one-cycle ready.
//
// Build option:
//   SQU_KER_1X1_EN - when defined, the 1x1 RAM and output path are built;
//                    otherwise squ_1x1_ker_o is tied to zero.
//
// Ports:
//   clk_i                 in  1    clock
//   rst_i                 in  1    synchronous active-high reset
//   start_i               in  1    begin layer / rewind read pointer
//   exp_1x1_en_i          in  1    gate for the 1x1 output
//   tot_ker_addr_limit_i  in  9    last read address of the layer
//   ker_clr_i             in  1    clear write pointer and loaded count
//   ker_wr_en_i           in  1    write one kernel pair
//   ker_3x3_wr_data_i     in  64   3x3 kernel word
//   ker_1x1_wr_data_i     in  64   1x1 kernel word
//   ker_wr_count_o        out 10   words loaded, 0..512
//   squ_ker_req_i         in  1    request pulse
//   squ_ker_ready_o       out 1    ready pulse, outputs valid from this cycle
//   squ_3x3_ker_o         out 64   3x3 kernel, held until next ready
//   squ_1x1_ker_o         out 64   1x1 kernel, held until next ready
//   busy_o                out 1    request pending or read in flight
// -----------------------------------------------------------------------------
module squeeze_kernel_server #(
    parameter int KER_DEPTH = squ_ker_pkg::KER_DEPTH,
    parameter int KER_W     = squ_ker_pkg::KER_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           exp_1x1_en_i,
    input  logic [$clog2(KER_DEPTH)-1:0]   tot_ker_addr_limit_i,
    input  logic                           ker_clr_i,
    input  logic                           ker_wr_en_i,
    input  logic [KER_W-1:0]               ker_3x3_wr_data_i,
    input  logic [KER_W-1:0]               ker_1x1_wr_data_i,
    output logic [$clog2(KER_DEPTH):0]     ker_wr_count_o,
    input  logic                           squ_ker_req_i,
    output logic                           squ_ker_ready_o,
    output logic [KER_W-1:0]               squ_3x3_ker_o,
    output logic [KER_W-1:0]               squ_1x1_ker_o,
    output logic                           busy_o
);

    import squ_ker_pkg::*;

    localparam int             AW         = $clog2(KER_DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(KER_DEPTH);

    squ_state_e      state_q;
    squ_state_e      state_d;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     wr_count;
    logic [AW-1:0]   rd_ptr;
    logic            pending;
    logic            wr_fire;
    logic            rd_issue;
    logic            ready;
    logic [KER_W-1:0] ram_3x3_q;
    logic [KER_W-1:0] ker_3x3_q;

    // A clear beats a coincident write, and a full RAM never wraps.
    assign wr_fire = ker_wr_en_i && !ker_clr_i && (wr_count != FULL_COUNT);

    always_ff @(posedge clk_i) begin
        if (rst_i || ker_clr_i) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (wr_fire) begin
            wr_ptr   <= wr_ptr + 1'b1;
            wr_count <= wr_count + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start_i rewinds from any state, aborting a read in flight. RUN waits
    // for loaded data, which covers requests arriving while kernels load.
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                RUN: begin
                    if (pending && ({1'b0, rd_ptr} < wr_count)) begin
                        state_d = RD;
                    end
                end
                RD:      state_d = LAT;
                LAT:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Ready is suppressed by a same-cycle start or reset so an aborted read
    // never produces a pulse or disturbs the held outputs.
    always_comb begin
        rd_issue = (state_q == RUN) && (state_d == RD);
        ready    = (state_q == LAT) && !start_i && !rst_i;
        busy_o   = pending || (state_q == RD) || (state_q == LAT);
    end

    // A request seen while one is already pending is simply absorbed.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i || rd_issue) begin
            pending <= 1'b0;
        end else if (squ_ker_req_i) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            rd_ptr <= '0;
        end else if (ready) begin
            rd_ptr <= next_rd_ptr(rd_ptr, tot_ker_addr_limit_i);
        end
    end

    squ_ker_ram #(
        .DEPTH (KER_DEPTH),
        .W     (KER_W)
    ) u_ram_3x3 (
        .clk_i     (clk_i),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr),
        .wr_data_i (ker_3x3_wr_data_i),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr),
        .rd_data_o (ram_3x3_q)
    );

    // During the ready cycle the RAM word is forwarded directly; afterwards
    // the registered copy holds it until the next ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ker_3x3_q <= '0;
        end else if (ready) begin
            ker_3x3_q <= ram_3x3_q;
        end
    end

    assign squ_3x3_ker_o = ready ? ram_3x3_q : ker_3x3_q;

`ifdef SQU_KER_1X1_EN
    logic [KER_W-1:0] ram_1x1_q;
    logic [KER_W-1:0] ker_1x1_q;
    logic [KER_W-1:0] ker_1x1_sel;

    squ_ker_ram #(
        .DEPTH (KER_DEPTH),
        .W     (KER_W)
    ) u_ram_1x1 (
        .clk_i     (clk_i),
        .wr_en_i   (wr_fire),
        .wr_addr_i (wr_ptr),
        .wr_data_i (ker_1x1_wr_data_i),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr),
        .rd_data_o (ram_1x1_q)
    );

    // The RAM is still loaded when the 1x1 path is disabled; only the
    // delivered word is zeroed.
    assign ker_1x1_sel = exp_1x1_en_i ? ram_1x1_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ker_1x1_q <= '0;
        end else if (ready) begin
            ker_1x1_q <= ker_1x1_sel;
        end
    end

    assign squ_1x1_ker_o = ready ? ker_1x1_sel : ker_1x1_q;
`else
    logic unused_1x1;
    assign unused_1x1    = ^{ker_1x1_wr_data_i, exp_1x1_en_i};
    assign squ_1x1_ker_o = '0;
`endif

    assign squ_ker_ready_o = ready;
    assign ker_wr_count_o  = wr_count;

endmodule

// File: tb/tb_squeeze_kernel_server.sv
// -----------------------------------------------------------------------------
// tb_squeeze_kernel_server
// Directed self-checking bench for squeeze_kernel_server. Expected values are
// hand-derived constants; the 1x1 expectation follows SQU_KER_1X1_EN.
// -----------------------------------------------------------------------------
module tb_squeeze_kernel_server;

`ifdef SQU_KER_1X1_EN
    localparam bit HAS_1X1 = 1'b1;
`else
    localparam bit HAS_1X1 = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        exp_1x1_en_i = 1'b1;
    logic [8:0]  tot_ker_addr_limit_i = 9'd0;
    logic        ker_clr_i = 1'b0;
    logic        ker_wr_en_i = 1'b0;
    logic [63:0] ker_3x3_wr_data_i = 64'h0;
    logic [63:0] ker_1x1_wr_data_i = 64'h0;
    logic [9:0]  ker_wr_count_o;
    logic        squ_ker_req_i = 1'b0;
    logic        squ_ker_ready_o;
    logic [63:0] squ_3x3_ker_o;
    logic [63:0] squ_1x1_ker_o;
    logic        busy_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    squeeze_kernel_server dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .start_i              (start_i),
        .exp_1x1_en_i         (exp_1x1_en_i),
        .tot_ker_addr_limit_i (tot_ker_addr_limit_i),
        .ker_clr_i            (ker_clr_i),
        .ker_wr_en_i          (ker_wr_en_i),
        .ker_3x3_wr_data_i    (ker_3x3_wr_data_i),
        .ker_1x1_wr_data_i    (ker_1x1_wr_data_i),
        .ker_wr_count_o       (ker_wr_count_o),
        .squ_ker_req_i        (squ_ker_req_i),
        .squ_ker_ready_o      (squ_ker_ready_o),
        .squ_3x3_ker_o        (squ_3x3_ker_o),
        .squ_1x1_ker_o        (squ_1x1_ker_o),
        .busy_o               (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs driven now are sampled at that edge and
    // outputs are read 1 time unit after it.
    task automatic applyStimulus();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] e1(input logic [63:0] v);
        return HAS_1X1 ? v : 64'h0;
    endfunction

    task automatic load_pair(input logic [63:0] d3, input logic [63:0] d1);
        ker_wr_en_i       = 1'b1;
        ker_3x3_wr_data_i = d3;
        ker_1x1_wr_data_i = d1;
        applyStimulus();
        ker_wr_en_i = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1;
        applyStimulus();
        start_i = 1'b0;
    endtask

    // Request in the current cycle and expect ready exactly 3 cycles later.
    task automatic request_kernel(input string tag, input logic [63:0] exp3,
                                  input logic [63:0] exp1);
        int lat;
        lat = 0;
        squ_ker_req_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus();
            squ_ker_req_i = 1'b0;
            if (squ_ker_ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'd3);
        checkOutput({tag, " 3x3"}, squ_3x3_ker_o, exp3);
        checkOutput({tag, " 1x1"}, squ_1x1_ker_o, exp1);
    endtask

    initial begin
        int lat;
        bit seen;

        $display("[TB] squeeze_kernel_server bench, 1x1 path built = %0d", HAS_1X1);

        // Reset values
        applyStimulus();
        applyStimulus();
        checkOutput("reset ready", 64'(squ_ker_ready_o), 64'd0);
        checkOutput("reset 3x3", squ_3x3_ker_o, 64'h0);
        checkOutput("reset 1x1", squ_1x1_ker_o, 64'h0);
        checkOutput("reset count", 64'(ker_wr_count_o), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        rst_i = 1'b0;
        applyStimulus();

        // Basic read-out and wrap-around
        load_pair(64'h11, 64'hA1);
        load_pair(64'h22, 64'hA2);
        load_pair(64'h33, 64'hA3);
        load_pair(64'h44, 64'hA4);
        checkOutput("load count", 64'(ker_wr_count_o), 64'd4);
        tot_ker_addr_limit_i = 9'd3;
        exp_1x1_en_i = 1'b1;
        start_pulse();
        request_kernel("read0", 64'h11, e1(64'hA1));
        request_kernel("read1", 64'h22, e1(64'hA2));
        request_kernel("read2", 64'h33, e1(64'hA3));
        request_kernel("read3", 64'h44, e1(64'hA4));
        request_kernel("wrap0", 64'h11, e1(64'hA1));
        request_kernel("wrap1", 64'h22, e1(64'hA2));
        applyStimulus();
        checkOutput("ready one cycle", 64'(squ_ker_ready_o), 64'd0);
        checkOutput("hold 3x3", squ_3x3_ker_o, 64'h22);
        checkOutput("hold 1x1", squ_1x1_ker_o, e1(64'hA2));
        checkOutput("idle busy", 64'(busy_o), 64'd0);

        // 1x1 gating
        exp_1x1_en_i = 1'b0;
        start_pulse();
        request_kernel("gate0", 64'h11, 64'h0);
        request_kernel("gate1", 64'h22, 64'h0);
        exp_1x1_en_i = 1'b1;

        // Load stall: request with nothing loaded, write 5 cycles later
        ker_clr_i = 1'b1;
        applyStimulus();
        ker_clr_i = 1'b0;
        checkOutput("clear count", 64'(ker_wr_count_o), 64'd0);
        start_pulse();
        squ_ker_req_i = 1'b1;
        applyStimulus();
        squ_ker_req_i = 1'b0;
        checkOutput("stall busy", 64'(busy_o), 64'd1);
        seen = squ_ker_ready_o;
        repeat (4) begin
            applyStimulus();
            seen = seen | squ_ker_ready_o;
        end
        checkOutput("stall early ready", 64'(seen), 64'd0);
        ker_wr_en_i       = 1'b1;
        ker_3x3_wr_data_i = 64'h55;
        ker_1x1_wr_data_i = 64'hB5;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus();
            ker_wr_en_i = 1'b0;
            if (squ_ker_ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput("stall latency", 64'(lat), 64'd3);
        checkOutput("stall 3x3", squ_3x3_ker_o, 64'h55);
        checkOutput("stall 1x1", squ_1x1_ker_o, e1(64'hB5));

        // Write full: 513th write is dropped, address 0 keeps its word
        ker_clr_i = 1'b1;
        applyStimulus();
        ker_clr_i = 1'b0;
        for (int i = 0; i < 513; i++) begin
            ker_wr_en_i       = 1'b1;
            ker_3x3_wr_data_i = 64'h1000 + 64'(i);
            ker_1x1_wr_data_i = 64'h2000 + 64'(i);
            applyStimulus();
        end
        ker_wr_en_i = 1'b0;
        checkOutput("full count", 64'(ker_wr_count_o), 64'd512);
        start_pulse();
        request_kernel("full addr0", 64'h1000, e1(64'h2000));
        ker_clr_i   = 1'b1;
        ker_wr_en_i = 1'b1;
        applyStimulus();
        ker_clr_i   = 1'b0;
        ker_wr_en_i = 1'b0;
        checkOutput("clear beats write", 64'(ker_wr_count_o), 64'd0);

        // Reset while in RD
        load_pair(64'h66, 64'hC6);
        load_pair(64'h77, 64'hC7);
        tot_ker_addr_limit_i = 9'd1;
        start_pulse();
        squ_ker_req_i = 1'b1;
        applyStimulus();
        squ_ker_req_i = 1'b0;
        applyStimulus();
        rst_i = 1'b1;
        applyStimulus();
        rst_i = 1'b0;
        #1;
        seen = squ_ker_ready_o;
        checkOutput("rst in RD 3x3", squ_3x3_ker_o, 64'h0);
        checkOutput("rst in RD 1x1", squ_1x1_ker_o, 64'h0);
        checkOutput("rst in RD busy", 64'(busy_o), 64'd0);
        checkOutput("rst in RD count", 64'(ker_wr_count_o), 64'd0);
        repeat (3) begin
            applyStimulus();
            seen = seen | squ_ker_ready_o;
        end
        checkOutput("rst in RD no ready", 64'(seen), 64'd0);

        // Request in IDLE is held pending but nothing is read
        load_pair(64'h66, 64'hC6);
        load_pair(64'h77, 64'hC7);
        squ_ker_req_i = 1'b1;
        applyStimulus();
        squ_ker_req_i = 1'b0;
        checkOutput("idle req busy", 64'(busy_o), 64'd1);
        seen = squ_ker_ready_o;
        repeat (4) begin
            applyStimulus();
            seen = seen | squ_ker_ready_o;
        end
        checkOutput("idle no ready", 64'(seen), 64'd0);

        // Start while in LAT aborts the read and rewinds to address 0
        start_pulse();
        request_kernel("pre-abort", 64'h66, e1(64'hC6));
        squ_ker_req_i = 1'b1;
        applyStimulus();
        squ_ker_req_i = 1'b0;
        applyStimulus();
        applyStimulus();
        start_i = 1'b1;
        #1;
        checkOutput("start in LAT ready", 64'(squ_ker_ready_o), 64'd0);
        checkOutput("start in LAT hold", squ_3x3_ker_o, 64'h66);
        applyStimulus();
        start_i = 1'b0;
        checkOutput("after abort ready", 64'(squ_ker_ready_o), 64'd0);
        request_kernel("after abort", 64'h66, e1(64'hC6));
        request_kernel("after abort next", 64'h77, e1(64'hC7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
